// File: rtl/common_pkg.sv
// Shared execute-stage types for the HI/LO multiply/divide resource.
package common;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    function automatic word_t neg_if(input logic neg, input word_t val);
        return neg ? word_t'(-val) : val;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if it did not go negative.
module div_step
    import common::*;
(
    input  word_t rem_i,
    input  word_t quo_i,
    input  word_t dvs_i,
    output word_t rem_o,
    output word_t quo_o
);

    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        rem_sh = {rem_i, quo_i[31]};
        diff   = rem_sh - {1'b0, dvs_i};
        if (diff[32]) begin
            rem_o = rem_sh[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end else begin
            rem_o = diff[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step restoring
// divide, MTHI/MTLO writes, flush abort; holds busy_o while an op is in flight.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting requests; MT writes complete here in one edge
// ST_MUL  | product travelling down the multiply pipe, counter running
// ST_DIV  | one restoring step per cycle on operand magnitudes
module muldiv_ctrl
    import common::*;
#(
    parameter int MUL_LAT = 4
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid_i,
    input  muldiv_op_t op_i,
    input  word_t      a_i,
    input  word_t      b_i,
    input  logic       flush_i,
    output logic       busy_o,
    output logic       done_o,
    output word_t      hi_o,
    output word_t      lo_o
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    word_t rem_q;
    word_t quo_q;
    word_t dvs_q;
    word_t dividend_q;
    logic  neg_quo_q;
    logic  neg_rem_q;
    logic  div_zero_q;

    logic [63:0] mul_pipe [MUL_LAT];

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    word_t       rem_nx;
    word_t       quo_nx;
    word_t       rem_fin;
    word_t       quo_fin;
    logic        last_mul;
    logic        last_div;

    // Sign/zero extension to 64 bits makes one unsigned multiply serve both
    // MULT and MULTU: the low 64 bits of the product are identical.
    always_comb begin
        is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
        a_neg     = is_signed & a_i[31];
        b_neg     = is_signed & b_i[31];
        ext_a     = {{32{a_neg}}, a_i};
        ext_b     = {{32{b_neg}}, b_i};
        product   = ext_a * ext_b;
        last_mul  = (cnt == CNT_W'(MUL_LAT - 1));
        last_div  = (cnt == CNT_W'(DIV_ITERS - 1));
    end

    div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    // Divide by zero bypasses sign correction so both flavours return all-ones / dividend.
    always_comb begin
        quo_fin = div_zero_q ? '1 : neg_if(neg_quo_q, quo_nx);
        rem_fin = div_zero_q ? dividend_q : neg_if(neg_rem_q, rem_nx);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe[i] <= '0;
            end
        end else begin
            mul_pipe[0] <= product;
            for (int i = 1; i < MUL_LAT; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dividend_q <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy_o <= 1'b0;
                    cnt    <= '0;
                    if (valid_i && !flush_i) begin
                        case (op_i)
                            MD_MTHI: hi_o <= a_i;
                            MD_MTLO: lo_o <= a_i;
                            MD_MULT, MD_MULTU: begin
                                state  <= ST_MUL;
                                busy_o <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                state      <= ST_DIV;
                                busy_o     <= 1'b1;
                                rem_q      <= '0;
                                quo_q      <= neg_if(a_neg, a_i);
                                dvs_q      <= neg_if(b_neg, b_i);
                                dividend_q <= a_i;
                                neg_quo_q  <= a_neg ^ b_neg;
                                neg_rem_q  <= a_neg;
                                div_zero_q <= (b_i == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (last_mul) begin
                            {hi_o, lo_o} <= mul_pipe[MUL_LAT-1];
                            done_o       <= 1'b1;
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_DIV: begin
                    if (flush_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (last_div) begin
                            hi_o   <= rem_fin;
                            lo_o   <= quo_fin;
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: arithmetic reference model plus directed operations
// with hand-computed results, latencies, flush and async reset.
module tb_muldiv_ctrl;
    import common::*;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk;
    logic       resetn;
    logic       valid_i;
    muldiv_op_t op_i;
    word_t      a_i;
    word_t      b_i;
    logic       flush_i;
    logic       busy_o;
    logic       done_o;
    word_t      hi_o;
    word_t      lo_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .valid_i (valid_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Reference model: an op in flight is just a result waiting out its latency.
    int    remaining;
    logic  m_busy;
    logic  m_done;
    word_t m_hi;
    word_t m_lo;
    word_t pend_hi;
    word_t pend_lo;

    function automatic logic [63:0] ref_mul(input muldiv_op_t op, input word_t a, input word_t b);
        longint sa, sb;
        if (op == MD_MULT) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] ref_div(input muldiv_op_t op, input word_t a, input word_t b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == MD_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remaining = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (remaining > 0) begin
                if (flush_i) begin
                    remaining = 0;
                    m_busy = 1'b0;
                end else begin
                    remaining--;
                    if (remaining == 0) begin
                        m_hi = pend_hi;
                        m_lo = pend_lo;
                        m_done = 1'b1;
                    end
                end
            end else begin
                m_busy = 1'b0;
                if (valid_i && !flush_i) begin
                    case (op_i)
                        MD_MTHI: m_hi = a_i;
                        MD_MTLO: m_lo = a_i;
                        MD_MULT, MD_MULTU: begin
                            {pend_hi, pend_lo} = ref_mul(op_i, a_i, b_i);
                            remaining = MUL_LAT;
                            m_busy = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            {pend_hi, pend_lo} = ref_div(op_i, a_i, b_i);
                            remaining = DIV_LAT;
                            m_busy = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            check("cyc busy", 32'(busy_o), 32'(m_busy));
            check("cyc done", 32'(done_o), 32'(m_done));
            check("cyc hi", hi_o, m_hi);
            check("cyc lo", lo_o, m_lo);
        end
    end

    task automatic run_op(input string name, input muldiv_op_t op, input word_t a, input word_t b,
                          input int lat, input word_t ehi, input word_t elo);
        int cyc;
        @(posedge clk); #1;
        valid_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        cyc = 0;
        while (done_o !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " hi"}, hi_o, ehi);
        check({name, " lo"}, lo_o, elo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        resetn = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i = MD_MULT;
        a_i = '0;
        b_i = '0;
        #23;
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst hi", hi_o, 32'd0);
        check("rst lo", lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        @(posedge clk); #1;
        valid_i = 1'b1; op_i = MD_MTHI; a_i = 32'h1234_5678;
        @(posedge clk); #1;
        check("mthi hi", hi_o, 32'h1234_5678);
        check("mthi busy", 32'(busy_o), 32'd0);
        op_i = MD_MTLO; a_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("mtlo lo", lo_o, 32'hDEAD_BEEF);
        check("mtlo busy", 32'(busy_o), 32'd0);

        flush_i = 1'b1; valid_i = 1'b1; op_i = MD_MTHI; a_i = 32'hAAAA_5555;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check("flushed mthi hi", hi_o, 32'h1234_5678);

        run_op("mult neg", MD_MULT,  32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu",    MD_MULTU, 32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("mult m1sq", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'h0, 32'h1);
        run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h1);
        run_op("div neg",  MD_DIV,  32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div negb", MD_DIV,  32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'h1, 32'hFFFF_FFFD);
        run_op("divu",     MD_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
        run_op("divu z",   MD_DIVU, 32'd5, 32'd0, DIV_LAT, 32'd5, 32'hFFFF_FFFF);
        run_op("div z",    MD_DIV,  32'hFFFF_FFF9, 32'd0, DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000);

        @(posedge clk); #1;
        valid_i = 1'b1; op_i = MD_DIVU; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush busy", 32'(busy_o), 32'd0);
        check("flush hi", hi_o, 32'h0);
        check("flush lo", lo_o, 32'h8000_0000);
        done_seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done_o) done_seen++;
        end
        check("flush no done", 32'(done_seen), 32'd0);
        run_op("mult after flush", MD_MULT, 32'd7, 32'd6, MUL_LAT, 32'h0, 32'h2A);

        @(posedge clk); #1;
        valid_i = 1'b1; op_i = MD_MULT; a_i = 32'd3; b_i = 32'd5;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #2;
        check("pre-reset busy", 32'(busy_o), 32'd1);
        resetn = 1'b0;
        #1;
        check("async rst busy", 32'(busy_o), 32'd0);
        check("async rst done", 32'(done_o), 32'd0);
        check("async rst hi", hi_o, 32'd0);
        check("async rst lo", lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("mult after rst", MD_MULT, 32'hFFFF_0000, 32'h0001_0000, MUL_LAT, 32'hFFFF_FFFF, 32'h0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
